optic_rx: RTL and testbench

Serial optic frame receiver, downstream of the optic transmitter across the fibre link. It samples one bit per `clk_tx` cycle from the PHY receive pin and locks onto the 12-byte frame (header 0x01, 8 payload bytes, CRC-16 MSB/LSB, tail 0xFF, MSB first). It checks CRC and tail, then presents the 64-bit payload with a one-cycle valid strobe. It also reports link faults: a stuck line, or idle toggling lost. Clock-domain crossing to `clk_sys` is done by the consumer, not here.

---
 rtl/optic_pkg.sv | 33 +++
 rtl/crc16_serial.sv | 35 +++
 rtl/optic_rx.sv | 216 +++++++++++++++++++++
 tb/tb_optic_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/optic_pkg.sv
// optic_pkg: constants and types shared by the optic link TX and RX sides.
//   Frame layout (MSB first): header, 8 payload bytes, CRC[15:8], CRC[7:0], tail.
//   crc16_step: one MSB-first bit step of CRC-16/CCITT (poly 0x1021).
package optic_pkg;

    localparam logic [7:0]  OPTIC_HDR    = 8'h01;
    localparam logic [7:0]  OPTIC_TAIL   = 8'hFF;
    localparam logic [15:0] CRC16_POLY   = 16'h1021;
    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

    localparam int PAYLOAD_BITS = 64;
    localparam int CRC_BITS     = 16;
    localparam int TAIL_BITS    = 8;

    localparam logic [5:0] PAYLOAD_LAST = 6'(PAYLOAD_BITS - 1);
    localparam logic [5:0] CRC_LAST     = 6'(CRC_BITS - 1);
    localparam logic [5:0] TAIL_LAST    = 6'(TAIL_BITS - 1);

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        PAYLOAD = 3'd1,
        CRC     = 3'd2,
        TAIL    = 3'd3,
        CHECK   = 3'd4
    } optic_state_e;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc_in, input logic din);
        logic fb;
        fb = crc_in[15] ^ din;
        return {crc_in[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/crc16_serial.sv
// crc16_serial: bit-serial CRC-16/CCITT engine, one bit per clock, MSB first.
//   clk  : clock
//   init : load CRC16_INIT (has priority over en)
//   en   : advance the CRC by one bit using din
//   din  : serial data bit
//   crc  : current CRC register
module crc16_serial
    import optic_pkg::*;
(
    input  logic        clk,
    input  logic        init,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC16_INIT;
        end else if (en) begin
            crc_d = crc16_step(crc_q, din);
        end
    end

    always_ff @(posedge clk) begin
        crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/optic_rx.sv
// optic_rx: serial optic frame receiver.
//   Samples phy_rxd once per clk_tx through a 2-FF synchronizer, hunts for the
//   header byte, collects payload/CRC/tail and checks them, and monitors the
//   idle line for stuck runs.
// Ports:
//   clk_tx       : bit clock
//   reset        : synchronous, active-high
//   phy_rxd      : serial receive line
//   rx_data      : last good 64-bit payload (first byte in [63:56])
//   rx_valid     : one-cycle pulse, good frame
//   rx_crc_err   : one-cycle pulse, CRC mismatch
//   rx_tail_err  : one-cycle pulse, bad tail with good CRC
//   link_fault   : level, line stuck while hunting
//   rx_frame_cnt : good frame count, wraps
//   rx_err_cnt   : CRC + tail error count, saturates
//
// state   | meaning
// HUNT    | shift line into 8-bit window, wait for header, watch run length
// PAYLOAD | 64 payload bits, CRC engine running
// CRC     | 16 received CRC bits
// TAIL    | 8 tail bits
// CHECK   | one cycle: compare CRC/tail, emit pulse; current bit enters window
module optic_rx
    import optic_pkg::*;
#(
    parameter int RUN_LIMIT = 32
) (
    input  logic        clk_tx,
    input  logic        reset,
    input  logic        phy_rxd,
    output logic [63:0] rx_data,
    output logic        rx_valid,
    output logic        rx_crc_err,
    output logic        rx_tail_err,
    output logic        link_fault,
    output logic [15:0] rx_frame_cnt,
    output logic [15:0] rx_err_cnt
);

    localparam logic [5:0] RUN_CNT_LIMIT = 6'(RUN_LIMIT);

    optic_state_e state_q, state_d;
    logic         sync1_q, sync1_d;
    logic         s_q, s_d;
    logic         s_prev_q, s_prev_d;
    logic [7:0]   window_q, window_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [63:0]  payload_q, payload_d;
    logic [15:0]  crc_rx_q, crc_rx_d;
    logic [7:0]   tail_rx_q, tail_rx_d;
    logic [5:0]   run_q, run_d;
    logic         fault_q, fault_d;
    logic [63:0]  data_q, data_d;
    logic         valid_q, valid_d;
    logic         crc_err_q, crc_err_d;
    logic         tail_err_q, tail_err_d;
    logic [15:0]  frame_cnt_q, frame_cnt_d;
    logic [15:0]  err_cnt_q, err_cnt_d;

    logic         crc_init;
    logic         crc_en;
    logic [15:0]  crc_calc;
    logic [7:0]   window_shift;

    crc16_serial u_crc (
        .clk  (clk_tx),
        .init (reset | crc_init),
        .en   (crc_en),
        .din  (s_q),
        .crc  (crc_calc)
    );

    always_comb begin
        state_d      = state_q;
        sync1_d      = phy_rxd;
        s_d          = sync1_q;
        s_prev_d     = s_q;
        window_d     = window_q;
        cnt_d        = cnt_q;
        payload_d    = payload_q;
        crc_rx_d     = crc_rx_q;
        tail_rx_d    = tail_rx_q;
        run_d        = 6'd0;
        fault_d      = fault_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        crc_err_d    = 1'b0;
        tail_err_d   = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        err_cnt_d    = err_cnt_q;
        crc_init     = 1'b0;
        crc_en       = 1'b0;
        window_shift = {window_q[6:0], s_q};

        case (state_q)
            HUNT: begin
                window_d = window_shift;
                if (s_q == s_prev_q) begin
                    run_d = (run_q == 6'h3F) ? run_q : run_q + 6'd1;
                end else begin
                    run_d = 6'd0;
                end
                if (run_d == 6'd0) begin
                    fault_d = 1'b0;
                end else if (run_d >= RUN_CNT_LIMIT) begin
                    fault_d = 1'b1;
                end
                // Compare the window including this cycle's bit so the first
                // payload bit is captured in the very next cycle.
                if (window_shift == OPTIC_HDR) begin
                    state_d  = PAYLOAD;
                    cnt_d    = 6'd0;
                    crc_init = 1'b1;
                end
            end
            PAYLOAD: begin
                payload_d = {payload_q[62:0], s_q};
                crc_en    = 1'b1;
                cnt_d     = cnt_q + 6'd1;
                if (cnt_q == PAYLOAD_LAST) begin
                    state_d = CRC;
                    cnt_d   = 6'd0;
                end
            end
            CRC: begin
                crc_rx_d = {crc_rx_q[14:0], s_q};
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == CRC_LAST) begin
                    state_d = TAIL;
                    cnt_d   = 6'd0;
                end
            end
            TAIL: begin
                tail_rx_d = {tail_rx_q[6:0], s_q};
                cnt_d     = cnt_q + 6'd1;
                if (cnt_q == TAIL_LAST) begin
                    state_d = CHECK;
                    cnt_d   = 6'd0;
                end
            end
            CHECK: begin
                if (crc_calc != crc_rx_q) begin
                    crc_err_d = 1'b1;
                end else if (tail_rx_q != OPTIC_TAIL) begin
                    tail_err_d = 1'b1;
                end else begin
                    valid_d     = 1'b1;
                    data_d      = payload_q;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
                if ((crc_calc != crc_rx_q) || (tail_rx_q != OPTIC_TAIL)) begin
                    if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                end
                // Reload the window, but keep the bit arriving now: it may be
                // the first header bit of a back-to-back frame.
                window_d = {7'h7F, s_q};
                state_d  = HUNT;
            end
            default: begin
                state_d  = HUNT;
                window_d = 8'hFF;
            end
        endcase
    end

    always_ff @(posedge clk_tx) begin
        if (reset) begin
            state_q     <= HUNT;
            sync1_q     <= 1'b0;
            s_q         <= 1'b0;
            s_prev_q    <= 1'b0;
            window_q    <= 8'hFF;
            cnt_q       <= 6'd0;
            payload_q   <= 64'd0;
            crc_rx_q    <= 16'd0;
            tail_rx_q   <= 8'd0;
            run_q       <= 6'd0;
            fault_q     <= 1'b0;
            data_q      <= 64'd0;
            valid_q     <= 1'b0;
            crc_err_q   <= 1'b0;
            tail_err_q  <= 1'b0;
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            s_q         <= s_d;
            s_prev_q    <= s_prev_d;
            window_q    <= window_d;
            cnt_q       <= cnt_d;
            payload_q   <= payload_d;
            crc_rx_q    <= crc_rx_d;
            tail_rx_q   <= tail_rx_d;
            run_q       <= run_d;
            fault_q     <= fault_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            crc_err_q   <= crc_err_d;
            tail_err_q  <= tail_err_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign rx_data      = data_q;
    assign rx_valid     = valid_q;
    assign rx_crc_err   = crc_err_q;
    assign rx_tail_err  = tail_err_q;
    assign link_fault   = fault_q;
    assign rx_frame_cnt = frame_cnt_q;
    assign rx_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_optic_rx.sv
// tb_optic_rx: scoreboard bench for optic_rx. Frames are built with a
// bench-side CRC model; the expected pulse kind, payload and counters are
// queued when the last tail bit is driven and checked when the pulse is due.
module tb_optic_rx;
    import optic_pkg::*;

    logic        clk_tx = 1'b0;
    logic        reset;
    logic        phy_rxd;
    logic [63:0] rx_data;
    logic        rx_valid;
    logic        rx_crc_err;
    logic        rx_tail_err;
    logic        link_fault;
    logic [15:0] rx_frame_cnt;
    logic [15:0] rx_err_cnt;

    optic_rx #(.RUN_LIMIT(32)) dut (
        .clk_tx       (clk_tx),
        .reset        (reset),
        .phy_rxd      (phy_rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_crc_err   (rx_crc_err),
        .rx_tail_err  (rx_tail_err),
        .link_fault   (link_fault),
        .rx_frame_cnt (rx_frame_cnt),
        .rx_err_cnt   (rx_err_cnt)
    );

    always #5 clk_tx = ~clk_tx;

    int cyc = 0;
    always @(posedge clk_tx) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    typedef struct {
        logic [2:0]  kind;   // {valid, crc_err, tail_err}
        logic [63:0] data;
        logic [15:0] fcnt;
        logic [15:0] ecnt;
        int          due;
    } exp_t;

    exp_t q[$];

    logic [63:0] m_data = 64'd0;
    logic [15:0] m_fcnt = 16'd0;
    logic [15:0] m_ecnt = 16'd0;

    function automatic logic [15:0] crc_model(input logic [63:0] p);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int b = 0; b < 8; b++) begin
            c = c ^ {p[63 - 8*b -: 8], 8'h00};
            for (int k = 0; k < 8; k++) begin
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
            end
        end
        return c;
    endfunction

    task automatic drive_bit(input logic b);
        phy_rxd = b;
        @(posedge clk_tx);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_bit(i[0]);
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) drive_bit(b);
    endtask

    task automatic send_frame(input logic [63:0] pay, input int flip, input logic [7:0] tail);
        logic [15:0] c;
        logic [63:0] tx;
        logic [95:0] fr;
        exp_t        e;
        c  = crc_model(pay);
        tx = pay;
        if (flip >= 0) tx[flip] = ~tx[flip];
        fr = {8'h01, tx, c, tail};
        if (crc_model(tx) != c) begin
            e.kind = 3'b010;
        end else if (tail != 8'hFF) begin
            e.kind = 3'b001;
        end else begin
            e.kind = 3'b100;
            m_data = tx;
            m_fcnt = m_fcnt + 16'd1;
        end
        if (e.kind != 3'b100 && m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 16'd1;
        e.data = m_data;
        e.fcnt = m_fcnt;
        e.ecnt = m_ecnt;
        for (int i = 95; i >= 0; i--) begin
            if (i == 0) begin
                e.due = cyc + 4;
                q.push_back(e);
            end
            drive_bit(fr[i]);
        end
    endtask

    always @(negedge clk_tx) begin : mon
        logic [2:0] k;
        exp_t       e;
        k = {rx_valid, rx_crc_err, rx_tail_err};
        if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("pulse_kind",   64'(k),            64'(e.kind));
            chk("rx_data",      rx_data,           e.data);
            chk("rx_frame_cnt", 64'(rx_frame_cnt), 64'(e.fcnt));
            chk("rx_err_cnt",   64'(rx_err_cnt),   64'(e.ecnt));
        end else if (k != 3'b000) begin
            chk("unexpected_pulse", 64'(k), 64'd0);
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},  rx_data, 64'd0);
        chk({tag, "_pulse"}, 64'({rx_valid, rx_crc_err, rx_tail_err}), 64'd0);
        chk({tag, "_fault"}, 64'(link_fault), 64'd0);
        chk({tag, "_fcnt"},  64'(rx_frame_cnt), 64'd0);
        chk({tag, "_ecnt"},  64'(rx_err_cnt), 64'd0);
    endtask

    initial begin
        logic [63:0] pay;
        int          kind;
        int          flip;
        logic [7:0]  tail;

        reset   = 1'b1;
        phy_rxd = 1'b0;
        repeat (3) @(posedge clk_tx);
        #1;
        chk_all_zero("reset");
        chk("reset_state", 64'(dut.state_q), 64'(HUNT));
        reset = 1'b0;

        idle(200);
        chk("idle_fault", 64'(link_fault), 64'd0);
        chk("idle_state", 64'(dut.state_q), 64'(HUNT));
        chk("idle_fcnt",  64'(rx_frame_cnt), 64'd0);

        send_frame(64'h0123456789ABCDEF, -1, 8'hFF);
        idle(20);
        chk("first_fcnt", 64'(rx_frame_cnt), 64'd1);

        send_frame(64'h0123456789ABCDEF, 17, 8'hFF);
        idle(20);
        send_frame(64'h0123456789ABCDEF, -1, 8'hFF);
        idle(20);
        send_frame(64'hFEDCBA9876543210, -1, 8'hFE);
        idle(20);

        hold(1'b0, 34);
        chk("fault_before_limit", 64'(link_fault), 64'd0);
        hold(1'b0, 1);
        chk("fault_at_limit", 64'(link_fault), 64'd1);
        hold(1'b0, 5);
        chk("fault_held", 64'(link_fault), 64'd1);
        send_frame(64'hA5A5_0F0F_3C3C_8001, -1, 8'hFF);
        chk("fault_cleared", 64'(link_fault), 64'd0);
        idle(20);

        for (int n = 0; n < 4; n++) begin
            pay  = {$urandom, $urandom};
            kind = $urandom_range(0, 2);
            flip = (kind == 1) ? $urandom_range(0, 63) : -1;
            tail = (kind == 2) ? 8'($urandom_range(0, 254)) : 8'hFF;
            send_frame(pay, flip, tail);
            idle(12);
        end

        // reset so the back-to-back scenario starts from zero counters
        reset = 1'b1;
        repeat (2) @(posedge clk_tx);
        #1;
        reset  = 1'b0;
        m_data = 64'd0;
        m_fcnt = 16'd0;
        m_ecnt = 16'd0;
        idle(20);

        send_frame(64'h1122334455667788, -1, 8'hFF);
        send_frame(64'h99AABBCCDDEEFF00, -1, 8'hFF);
        pay = 64'hDEADBEEFCAFEF00D;
        begin
            logic [95:0] fr;
            fr = {8'h01, pay, crc_model(pay), 8'hFF};
            for (int i = 95; i > 65; i--) drive_bit(fr[i]);
        end
        chk("b2b_fcnt", 64'(rx_frame_cnt), 64'd2);
        reset = 1'b1;
        repeat (2) @(posedge clk_tx);
        #1;
        chk_all_zero("midreset");
        reset  = 1'b0;
        m_data = 64'd0;
        m_fcnt = 16'd0;
        m_ecnt = 16'd0;
        idle(150);
        chk("post_reset_fcnt", 64'(rx_frame_cnt), 64'd0);

        send_frame(64'h0F1E2D3C4B5A6978, -1, 8'hFF);
        idle(12);
        chk("final_fcnt", 64'(rx_frame_cnt), 64'd1);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
